// File: rtl/seg_scan_pkg.sv
// Shared constants and the active-low seven-segment glyph decoder.
// Pure combinational helpers; no state, no handshake.
package seg_scan_pkg;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] BLANK = 7'h7F;

    // Active-low {g..a} glyphs for hex digits 0..F.
    localparam logic [SEG_W-1:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [4:0] seg_to_hex(input logic [SEG_W-1:0] pattern);
        seg_to_hex = 5'h00;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPH[i]) seg_to_hex = {1'b1, 4'(i)};
        end
    endfunction
endpackage

// File: rtl/seg_scan_capture_dwell.sv
// seg_dwell_detect: qualifies anode strobes and pulses cap when a digit has held still STABLE cycles.
// cap is combinational from registered history plus current inputs; no backpressure.
module seg_dwell_detect
    import seg_scan_pkg::*;
#(
    parameter int N      = 7,
    parameter int DIGITS = 4,
    parameter int STABLE = 4,
    parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIGITS-1:0] an,
    input  logic [N-1:0]      sseg,
    output logic              cap,
    output logic [IW-1:0]     idx
);
    localparam int CW = $clog2(STABLE + 1);

    logic [DIGITS-1:0] prev_an;
    logic [N-1:0]      prev_sseg;
    logic [CW-1:0]     cnt;
    logic              legal;
    logic              same;

    always_comb begin
        legal = ($countones(~an) == 1);
        idx   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an[i]) idx = IW'(i);
        end
        same = (an == prev_an) && (sseg == prev_sseg);
        // Reaching STABLE exactly once per dwell: the saturated count never re-fires.
        cap  = legal && same && (cnt == CW'(STABLE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_an   <= '1;
            prev_sseg <= '1;
            cnt       <= '0;
        end else begin
            prev_an   <= an;
            prev_sseg <= sseg;
            if (!legal)
                cnt <= '0;
            else if (!same)
                cnt <= CW'(1);
            else if (cnt != CW'(STABLE))
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/seg_scan_capture.sv
// Reassembles scanned seven-segment digits into decoded frames; publishes on the completing capture edge.
// Frames held until accepted; a frame completing while one is held and not accepted is dropped, setting overrun.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int N      = 7,
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an,
    input  logic [N-1:0]          sseg,
    input  logic                  frame_ready,
    input  logic                  clr_ovr,
    output logic                  frame_valid,
    output logic [DIGITS*N-1:0]   frame_seg,
    output logic [DIGITS*4-1:0]   frame_hex,
    output logic [DIGITS-1:0]     frame_ok,
    output logic                  overrun
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic              cap;
    logic [IW-1:0]     idx;
    logic [N-1:0]      slot [DIGITS];
    logic [N-1:0]      cur  [DIGITS];
    logic [DIGITS-1:0] seen, seen_nxt;
    logic              complete, publish, drop;
    logic [DIGITS*N-1:0] seg_nxt;
    logic [DIGITS*4-1:0] hex_nxt;
    logic [DIGITS-1:0]   ok_nxt;
    logic [4:0]          dec;

    seg_dwell_detect #(.N(N), .DIGITS(DIGITS), .STABLE(STABLE), .IW(IW)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .an   (an),
        .sseg (sseg),
        .cap  (cap),
        .idx  (idx)
    );

    // The completed frame includes the slot being written this very cycle.
    always_comb begin
        seen_nxt = seen;
        if (cap) seen_nxt[idx] = 1'b1;
        complete = cap && (&seen_nxt);
        publish  = complete && (!frame_valid || frame_ready);
        drop     = complete && !publish;
        seg_nxt  = '0;
        hex_nxt  = '0;
        ok_nxt   = '0;
        dec      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            cur[i] = (cap && idx == IW'(i)) ? sseg : slot[i];
            dec    = seg_to_hex(cur[i]);
            seg_nxt[i*N +: N] = cur[i];
            hex_nxt[i*4 +: 4] = dec[3:0];
            ok_nxt[i]         = dec[4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) slot[i] <= BLANK;
            seen        <= '0;
            frame_valid <= 1'b0;
            frame_seg   <= '1;
            frame_hex   <= '0;
            frame_ok    <= '0;
            overrun     <= 1'b0;
        end else begin
            if (cap) begin
                slot[idx] <= sseg;
                seen      <= complete ? '0 : seen_nxt;
            end
            if (publish) begin
                frame_valid <= 1'b1;
                frame_seg   <= seg_nxt;
                frame_hex   <= hex_nxt;
                frame_ok    <= ok_nxt;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (drop)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench: directed vector table, hand-written corner sequences, then randomized scanning vs a reference model.
module tb_seg_scan_capture;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        frame_ready, clr_ovr;
    logic        frame_valid;
    logic [27:0] frame_seg;
    logic [15:0] frame_hex;
    logic [3:0]  frame_ok;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_capture #(.N(7), .DIGITS(4), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .sseg        (sseg),
        .frame_ready (frame_ready),
        .clr_ovr     (clr_ovr),
        .frame_valid (frame_valid),
        .frame_seg   (frame_seg),
        .frame_hex   (frame_hex),
        .frame_ok    (frame_ok),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] ref_glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: run length of the current (an, sseg) pair and the frame assembly.
    logic [3:0] m_prev_an;
    logic [6:0] m_prev_seg;
    int         m_run;
    logic [6:0] m_slot [4];
    logic [6:0] m_out  [4];
    logic [3:0] m_seen;
    logic       m_valid, m_ovr;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h0;
        for (int k = 0; k < 16; k++) if (p == ref_glyph[k]) r = {1'b1, 4'(k)};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_an  = 4'hF;
        m_prev_seg = 7'h7F;
        m_run      = 0;
        m_seen     = 4'h0;
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_slot[i] = 7'h7F;
            m_out[i]  = 7'h7F;
        end
    endtask

    task automatic model_update();
        int zeros, d;
        logic legal, capt, acc, pub, drp;
        zeros = 0; d = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; d = i; end
        legal = (zeros == 1);
        if (!legal) m_run = 0;
        else if (m_run > 0 && an == m_prev_an && sseg == m_prev_seg) m_run++;
        else m_run = 1;
        m_prev_an  = an;
        m_prev_seg = sseg;
        capt = legal && (m_run == STABLE);
        acc  = m_valid && frame_ready;
        pub  = 1'b0;
        drp  = 1'b0;
        if (capt) begin
            m_slot[d] = sseg;
            m_seen[d] = 1'b1;
            if (&m_seen) begin
                m_seen = 4'h0;
                if (!m_valid || frame_ready) pub = 1'b1;
                else drp = 1'b1;
            end
        end
        if (pub) begin
            m_out   = m_slot;
            m_valid = 1'b1;
        end else if (acc) begin
            m_valid = 1'b0;
        end
        if (drp) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
    endtask

    task automatic compare_model();
        logic [27:0] es;
        logic [15:0] eh;
        logic [3:0]  eo;
        logic [4:0]  dd;
        for (int i = 0; i < 4; i++) begin
            dd = ref_decode(m_out[i]);
            es[i*7 +: 7] = m_out[i];
            eh[i*4 +: 4] = dd[3:0];
            eo[i]        = dd[4];
        end
        check("model_valid", {31'd0, frame_valid}, {31'd0, m_valid});
        check("model_seg", {4'd0, frame_seg}, {4'd0, es});
        check("model_hex", {16'd0, frame_hex}, {16'd0, eh});
        check("model_ok", {28'd0, frame_ok}, {28'd0, eo});
        check("model_ovr", {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
        #1;
        compare_model();
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a;
        sseg = s;
        repeat (n) step();
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  sseg;
        int          cycles;
        logic        exp_valid;
        logic        exp_ovr;
        logic [15:0] exp_hex;
        logic [3:0]  exp_ok;
    } vec_t;

    vec_t vecs [13];

    initial begin
        rst = 1'b1; an = 4'hF; sseg = 7'h7F; frame_ready = 1'b0; clr_ovr = 1'b0;
        model_reset();
        #1;
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_seg", {4'd0, frame_seg}, 32'h0FFF_FFFF);
        check("rst_hex", {16'd0, frame_hex}, 32'd0);
        check("rst_ok", {28'd0, frame_ok}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        #7 rst = 1'b0;

        // Frame 1 (3,2,1,0), then glitches, a 3-cycle non-capture and a dropped frame 2.
        vecs[0]  = '{4'b1110, 7'h40, 6, 1'b0, 1'b0, 16'h0000, 4'h0};
        vecs[1]  = '{4'b1101, 7'h79, 6, 1'b0, 1'b0, 16'h0000, 4'h0};
        vecs[2]  = '{4'b1011, 7'h24, 6, 1'b0, 1'b0, 16'h0000, 4'h0};
        vecs[3]  = '{4'b0111, 7'h30, 6, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[4]  = '{4'b1111, 7'h7F, 2, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[5]  = '{4'b1110, 7'h7F, 3, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[6]  = '{4'b1111, 7'h7F, 1, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[7]  = '{4'b1110, 7'h7F, 4, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[8]  = '{4'b1100, 7'h40, 2, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[9]  = '{4'b1101, 7'h79, 3, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[10] = '{4'b1101, 7'h12, 5, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[11] = '{4'b1011, 7'h00, 5, 1'b1, 1'b0, 16'h3210, 4'hF};
        vecs[12] = '{4'b0111, 7'h0E, 5, 1'b1, 1'b1, 16'h3210, 4'hF};
        for (int v = 0; v < 13; v++) begin
            hold(vecs[v].an, vecs[v].sseg, vecs[v].cycles);
            check($sformatf("vec%0d_valid", v), {31'd0, frame_valid}, {31'd0, vecs[v].exp_valid});
            check($sformatf("vec%0d_ovr", v), {31'd0, overrun}, {31'd0, vecs[v].exp_ovr});
            check($sformatf("vec%0d_hex", v), {16'd0, frame_hex}, {16'd0, vecs[v].exp_hex});
            check($sformatf("vec%0d_ok", v), {28'd0, frame_ok}, {28'd0, vecs[v].exp_ok});
        end
        check("held_seg", {4'd0, frame_seg}, {4'd0, 7'h30, 7'h24, 7'h79, 7'h40});

        // One-cycle accept drops valid; clr_ovr clears the sticky flag.
        frame_ready = 1'b1; step(); frame_ready = 1'b0;
        check("accept_drop", {31'd0, frame_valid}, 32'd0);
        check("ovr_kept", {31'd0, overrun}, 32'd1);
        clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        check("ovr_clear", {31'd0, overrun}, 32'd0);

        // Frame 3 publishes into an empty output; frame 4 completes on an accept cycle.
        hold(4'b1110, 7'h79, 5); hold(4'b1101, 7'h24, 5);
        hold(4'b1011, 7'h30, 5); hold(4'b0111, 7'h19, 5);
        check("f3_valid", {31'd0, frame_valid}, 32'd1);
        check("f3_hex", {16'd0, frame_hex}, 32'h4321);
        hold(4'b1110, 7'h12, 5); hold(4'b1101, 7'h02, 5); hold(4'b1011, 7'h78, 5);
        hold(4'b0111, 7'h00, 3);
        frame_ready = 1'b1; step(); frame_ready = 1'b0;
        check("f4_valid", {31'd0, frame_valid}, 32'd1);
        check("f4_hex", {16'd0, frame_hex}, 32'h8765);
        check("f4_ovr", {31'd0, overrun}, 32'd0);
        step();

        // Asynchronous reset after two captured digits discards the partial frame.
        hold(4'b1110, 7'h40, 5); hold(4'b1101, 7'h79, 5);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
        check("mid_rst_seg", {4'd0, frame_seg}, 32'h0FFF_FFFF);
        check("mid_rst_hex", {16'd0, frame_hex}, 32'd0);
        #2 rst = 1'b0;
        hold(4'b1011, 7'h24, 5); hold(4'b0111, 7'h30, 5);
        check("partial_no_frame", {31'd0, frame_valid}, 32'd0);
        hold(4'b1110, 7'h40, 5); hold(4'b1101, 7'h79, 5);
        check("recap_valid", {31'd0, frame_valid}, 32'd1);
        check("recap_hex", {16'd0, frame_hex}, 32'h3210);

        // Randomized scanning with random backpressure and clears.
        for (int seg_i = 0; seg_i < 400; seg_i++) begin
            int r;
            logic [3:0] a;
            logic [6:0] s;
            r = $urandom_range(0, 9);
            if (r <= 6) begin
                a = 4'hF;
                a[$urandom_range(0, 3)] = 1'b0;
            end else if (r == 7) a = 4'hF;
            else a = 4'($urandom);
            if ($urandom_range(0, 3) != 0) s = ref_glyph[$urandom_range(0, 15)];
            else s = 7'($urandom);
            frame_ready = ($urandom_range(0, 3) == 0);
            clr_ovr     = ($urandom_range(0, 7) == 0);
            hold(a, s, $urandom_range(1, 6));
        end
        frame_ready = 1'b0;
        clr_ovr     = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
